ro_word_reader: RTL and testbench
=================================

// Module: ro_word_reader
// PURPOSE
//  Consumer side of the ring-oscillator entropy buffer. Enables both ROs, waits for the
//  XOR shift register to flush, then samples the buffer's registered byte output every
//  8 clocks so each sample holds 8 fresh, non-overlapping bits. Assembles WORD_BYTES
//  samples into one word, runs health checks, and hands the word out over valid/ready.
// PARAMETERS
//  WARMUP_CYCLES  80  clocks with ROs enabled before first sample period (>= 66 flushes 64b SR + 2 regs)
//  WORD_BYTES     8   bytes per output word; word width = 8*WORD_BYTES
//  REP_LIMIT      4   consecutive identical captured bytes that trip health_fail (>= 2)
// PORTS
//  clk            in   1     single clock; same clock as the entropy buffer
//  rst_n          in   1     reset, asynchronous, active-high (asserted = 1)
//  start          in   1     request one word; sampled only in IDLE with health_fail=0
//  cont           in   1     1 = after each handshake collect next word with no warm-up
//  clear_fail     in   1     clears sticky health_fail; honoured only in IDLE
//  byte_in        in   8     registered byte output of entropy buffer
//  out_sel        out  3     byte select to buffer; constant 3'b000 (low byte)
//  ro_activate_1  out  1     RO1 enable
//  ro_activate_2  out  1     RO2 enable
//  word_out       out  8*WB  assembled word, byte 0 in [7:0]
//  word_valid     out  1     word_out valid
//  word_ready     in   1     consumer accepts word
//  busy           out  1     1 in any state other than IDLE
//  health_fail    out  1     sticky health-test failure
// BEHAVIOUR
//  Reset: state IDLE; word_out=0, word_valid=0, busy=0, health_fail=0, ro_activate_*=0,
//   all counters 0. Reset mid-operation aborts at once, no partial word kept.
//  ro_activate_1 = ro_activate_2 = 1 in WARMUP, COLLECT and HOLD, else 0 (registered).
//  IDLE: start=1 & health_fail=0 -> WARMUP, wcnt=0. start ignored in other states.
//  WARMUP: wcnt counts up. Edge where wcnt==WARMUP_CYCLES-1 -> COLLECT, phase=0, idx=0.
//  COLLECT: phase 0..7 wraps. Edge with phase==7 captures byte_in into
//   word[8*idx +: 8], idx++. Captures land at COLLECT-entry + 8, +16, ... After capture
//   WORD_BYTES: health_fail=1 (existing or newly set) -> IDLE, word discarded, valid
//   stays 0. Otherwise -> HOLD with word_valid=1.
//  Start edge to word_valid high = WARMUP_CYCLES + 8*WORD_BYTES clocks (144 default).
//  HOLD: word_out and word_valid held stable until word_valid & word_ready on an edge.
//   On handshake: word_valid=0. cont=1 -> COLLECT (phase=0, idx=0, no warm-up, ROs
//   stay on). cont=0 -> IDLE. cont is sampled on the handshake edge.
//  Repetition test: each capture is compared with the previous capture. The history
//   spans word boundaries while in continuous mode and clears on leaving to IDLE.
//   Equal: rcnt++. Unequal: rcnt=1. First capture after IDLE: rcnt=1.
//   rcnt reaching REP_LIMIT sets health_fail on that edge.
//  Zero test: completed word equal to all zeros sets health_fail on the final-capture edge.
//  health_fail is sticky. It clears only on reset or on clear_fail=1 in IDLE.
//   clear_fail and start on the same IDLE edge: clear takes effect, start is ignored.
//  Counters are sized from the parameters with no overflow: wcnt counts to
//   WARMUP_CYCLES-1, idx counts to WORD_BYTES-1, rcnt saturates at REP_LIMIT.
// TESTING
//  1 Defaults. start pulse at edge 0. Bench drives byte_in 0x11..0x88 at the 8 capture
//    edges -> word_valid rises at edge 144, word_out=0x8877665544332211, health_fail=0.
//  2 Backpressure. Hold word_ready=0 for 20 clocks in HOLD -> word_out and valid
//    unchanged. ready=1 -> valid drops next edge. cont=0 -> IDLE, ROs off, busy=0.
//  3 Continuous. cont=1, handshake at edge H -> next word_valid at H+64, no warm-up,
//    ro_activate_* never deasserted.
//  4 Repetition. byte_in held at 0xA5 -> health_fail=1 at 4th capture (edge 112). Word
//    ends at edge 144 with word_valid=0 -> IDLE. start ignored until clear_fail pulse,
//    then start is accepted.
//  5 Zero word. REP_LIMIT=9, byte_in=0x00 throughout -> health_fail set at edge 144,
//    word_valid never asserted.
//  6 Reset mid-COLLECT. Assert rst_n at edge 100 -> all outputs 0 immediately. After
//    release and a new start, a clean word is produced exactly 144 clocks later.

Source files
------------

// File: rtl/ro_word_reader.sv
// Consumer of the ring-oscillator entropy buffer: warms up the ROs, samples one fresh
// byte every 8 clocks, assembles a word, health-checks it and offers it over valid/ready.
module ro_word_reader #(
    parameter int WARMUP_CYCLES = 80,
    parameter int WORD_BYTES    = 8,
    parameter int REP_LIMIT     = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    cont,
    input  logic                    clear_fail,
    input  logic [7:0]              byte_in,
    output logic [2:0]              out_sel,
    output logic                    ro_activate_1,
    output logic                    ro_activate_2,
    output logic [8*WORD_BYTES-1:0] word_out,
    output logic                    word_valid,
    input  logic                    word_ready,
    output logic                    busy,
    output logic                    health_fail
);
    localparam int WW  = 8 * WORD_BYTES;
    localparam int WCW = (WARMUP_CYCLES > 1) ? $clog2(WARMUP_CYCLES) : 1;
    localparam int IW  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
    localparam int RW  = $clog2(REP_LIMIT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WARMUP, S_COLLECT, S_HOLD} state_t;

    state_t         state_q, state_d;
    logic [WCW-1:0] wcnt_q, wcnt_d;
    logic [2:0]     phase_q, phase_d;
    logic [IW-1:0]  idx_q, idx_d;
    logic [WW-1:0]  word_q, word_d;
    logic           valid_q, valid_d;
    logic           fail_q, fail_d;
    logic [RW-1:0]  rcnt_q, rcnt_d;
    logic [7:0]     prev_q, prev_d;
    logic           ro_q, ro_d;

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= S_IDLE;
            wcnt_q  <= '0;
            phase_q <= '0;
            idx_q   <= '0;
            word_q  <= '0;
            valid_q <= 1'b0;
            fail_q  <= 1'b0;
            rcnt_q  <= '0;
            prev_q  <= '0;
            ro_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            phase_q <= phase_d;
            idx_q   <= idx_d;
            word_q  <= word_d;
            valid_q <= valid_d;
            fail_q  <= fail_d;
            rcnt_q  <= rcnt_d;
            prev_q  <= prev_d;
            ro_q    <= ro_d;
        end
    end

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        phase_d = phase_q;
        idx_d   = idx_q;
        word_d  = word_q;
        valid_d = valid_q;
        fail_d  = fail_q;
        rcnt_d  = rcnt_q;
        prev_d  = prev_q;
        case (state_q)
            S_IDLE: begin
                rcnt_d = '0;
                // Clear wins over start on the same edge.
                if (clear_fail) begin
                    fail_d = 1'b0;
                end else if (start && !fail_q) begin
                    state_d = S_WARMUP;
                    wcnt_d  = '0;
                end
            end
            S_WARMUP: begin
                if (wcnt_q == WCW'(WARMUP_CYCLES - 1)) begin
                    state_d = S_COLLECT;
                    phase_d = '0;
                    idx_d   = '0;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            S_COLLECT: begin
                phase_d = phase_q + 1'b1;
                if (phase_q == 3'd7) begin
                    word_d[8*idx_q +: 8] = byte_in;
                    // rcnt==0 means no previous capture since leaving IDLE.
                    if (rcnt_q != '0 && byte_in == prev_q) begin
                        if (rcnt_q != RW'(REP_LIMIT))
                            rcnt_d = rcnt_q + 1'b1;
                    end else begin
                        rcnt_d = RW'(1);
                    end
                    prev_d = byte_in;
                    if (rcnt_d == RW'(REP_LIMIT))
                        fail_d = 1'b1;
                    if (idx_q == IW'(WORD_BYTES - 1)) begin
                        if (word_d == '0)
                            fail_d = 1'b1;
                        if (fail_d) begin
                            state_d = S_IDLE;
                            rcnt_d  = '0;
                        end else begin
                            state_d = S_HOLD;
                            valid_d = 1'b1;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (word_ready) begin
                    valid_d = 1'b0;
                    if (cont) begin
                        state_d = S_COLLECT;
                        phase_d = '0;
                        idx_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                        rcnt_d  = '0;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
        ro_d = (state_d != S_IDLE);
    end

    assign out_sel       = 3'b000;
    assign ro_activate_1 = ro_q;
    assign ro_activate_2 = ro_q;
    assign word_out      = word_q;
    assign word_valid    = valid_q;
    assign busy          = (state_q != S_IDLE);
    assign health_fail   = fail_q;
endmodule

// File: tb/tb_ro_word_reader.sv
// Scenario bench for ro_word_reader: random entropy bytes, captures predicted from the
// 8-clock sampling rule and health results from a simple history model.
module tb_ro_word_reader;
    logic        clk, rst_n, start, cont, clear_fail, word_ready, sel;
    logic [7:0]  byte_in;
    logic [2:0]  a_sel, z_sel;
    logic        a_ro1, a_ro2, a_valid, a_busy, a_fail;
    logic        z_ro1, z_ro2, z_valid, z_busy, z_fail;
    logic [63:0] a_word, z_word;

    logic        o_ro1, o_ro2, o_valid, o_busy, o_fail;
    logic [63:0] o_word;
    logic [2:0]  o_sel;

    int vectors = 0;
    int errors  = 0;

    logic [63:0] m_word;
    logic        m_fail;
    int          m_rcnt;
    logic [7:0]  m_prev;
    int          lim;

    ro_word_reader dut (
        .clk(clk), .rst_n(rst_n), .start(start & ~sel), .cont(cont & ~sel),
        .clear_fail(clear_fail & ~sel), .byte_in(byte_in), .out_sel(a_sel),
        .ro_activate_1(a_ro1), .ro_activate_2(a_ro2), .word_out(a_word),
        .word_valid(a_valid), .word_ready(word_ready & ~sel), .busy(a_busy),
        .health_fail(a_fail)
    );

    ro_word_reader #(.REP_LIMIT(9)) dut_z (
        .clk(clk), .rst_n(rst_n), .start(start & sel), .cont(cont & sel),
        .clear_fail(clear_fail & sel), .byte_in(byte_in), .out_sel(z_sel),
        .ro_activate_1(z_ro1), .ro_activate_2(z_ro2), .word_out(z_word),
        .word_valid(z_valid), .word_ready(word_ready & sel), .busy(z_busy),
        .health_fail(z_fail)
    );

    assign o_ro1   = sel ? z_ro1   : a_ro1;
    assign o_ro2   = sel ? z_ro2   : a_ro2;
    assign o_valid = sel ? z_valid : a_valid;
    assign o_busy  = sel ? z_busy  : a_busy;
    assign o_fail  = sel ? z_fail  : a_fail;
    assign o_word  = sel ? z_word  : a_word;
    assign o_sel   = sel ? z_sel   : a_sel;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Start pulse (edge 0) followed by the 80 warm-up edges.
    task automatic start_and_warmup();
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            vectors++;
            if (o_busy !== 1'b1 || o_ro1 !== 1'b1 || o_ro2 !== 1'b1 || o_valid !== 1'b0) begin
                errors++;
                $display("FAIL warmup edge %0d: busy=%b ro=%b%b valid=%b, want busy=1 ro=11 valid=0",
                         i, o_busy, o_ro1, o_ro2, o_valid);
            end
            byte_in = 8'($urandom);
            tick();
        end
    endtask

    // mode 0: random bytes; 1: constant cval every clock; 2: 0x11*n at capture n, random between.
    task automatic collect(input int mode, input logic [7:0] cval, input int nk);
        logic [7:0] b;
        for (int k = 1; k <= nk; k++) begin
            if (mode == 1) b = cval;
            else if (mode == 2 && k % 8 == 0) b = 8'(8'h11 * (k / 8));
            else b = 8'($urandom);
            byte_in = b;
            tick();
            if (k % 8 == 0) begin
                m_word[8*(k/8-1) +: 8] = b;
                if (m_rcnt != 0 && b == m_prev) begin
                    if (m_rcnt < lim) m_rcnt++;
                end else begin
                    m_rcnt = 1;
                end
                m_prev = b;
                if (m_rcnt >= lim) m_fail = 1'b1;
                if (k == 64 && m_word == 64'd0) m_fail = 1'b1;
            end
            vectors++;
            if (o_fail !== m_fail) begin
                errors++;
                $display("FAIL health_fail collect k=%0d: got %b want %b", k, o_fail, m_fail);
            end
            if (k < 64) begin
                vectors++;
                if (o_valid !== 1'b0 || o_busy !== 1'b1 || o_ro1 !== 1'b1 || o_ro2 !== 1'b1) begin
                    errors++;
                    $display("FAIL collect k=%0d: valid=%b busy=%b ro=%b%b want 0 1 11",
                             k, o_valid, o_busy, o_ro1, o_ro2);
                end
            end else if (m_fail) begin
                m_rcnt = 0;
                vectors++;
                if (o_valid !== 1'b0 || o_busy !== 1'b0 || o_ro1 !== 1'b0) begin
                    errors++;
                    $display("FAIL failed word end: valid=%b busy=%b ro=%b want 0 0 0",
                             o_valid, o_busy, o_ro1);
                end
            end else begin
                vectors++;
                if (o_valid !== 1'b1 || o_word !== m_word || o_busy !== 1'b1) begin
                    errors++;
                    $display("FAIL word end: valid=%b word=%h busy=%b want 1 %h 1",
                             o_valid, o_word, o_busy, m_word);
                end
            end
        end
    endtask

    task automatic handshake(input logic cv);
        cont = cv;
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        cont = 1'b0;
        if (!cv) m_rcnt = 0;
        vectors++;
        if (o_valid !== 1'b0 || o_busy !== cv || o_ro1 !== cv || o_ro2 !== cv) begin
            errors++;
            $display("FAIL handshake cont=%b: valid=%b busy=%b ro=%b%b want 0 %b %b%b",
                     cv, o_valid, o_busy, o_ro1, o_ro2, cv, cv, cv);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1; start = 0; cont = 0; clear_fail = 0; word_ready = 0; sel = 0;
        byte_in = 8'h00;
        m_fail = 0; m_rcnt = 0; m_prev = 0; m_word = 0; lim = 4;
        tick(); tick();
        rst_n = 1'b0;
        tick();
        vectors++;
        if (o_word !== 64'd0 || o_valid !== 0 || o_busy !== 0 || o_fail !== 0 ||
            o_ro1 !== 0 || o_ro2 !== 0 || o_sel !== 3'b000) begin
            errors++;
            $display("FAIL reset state: word=%h valid=%b busy=%b fail=%b ro=%b%b sel=%b want all 0",
                     o_word, o_valid, o_busy, o_fail, o_ro1, o_ro2, o_sel);
        end
    endtask

    task automatic test_basic();
        start_and_warmup();
        collect(2, 8'h00, 64);
        vectors++;
        if (o_word !== 64'h8877665544332211) begin
            errors++;
            $display("FAIL basic word: got %h want 8877665544332211", o_word);
        end
    endtask

    task automatic test_backpressure();
        for (int i = 0; i < 20; i++) begin
            byte_in = 8'($urandom);
            tick();
            vectors++;
            if (o_valid !== 1'b1 || o_word !== m_word) begin
                errors++;
                $display("FAIL backpressure %0d: valid=%b word=%h want 1 %h", i, o_valid, o_word, m_word);
            end
        end
        handshake(1'b0);
    endtask

    task automatic test_continuous();
        start_and_warmup();
        collect(0, 8'h00, 64);
        for (int w = 0; w < 2; w++) begin
            handshake(1'b1);
            collect(0, 8'h00, 64);
        end
        handshake(1'b0);
    endtask

    task automatic test_repetition();
        start_and_warmup();
        collect(1, 8'hA5, 64);
        start = 1'b1;
        tick();
        start = 1'b0;
        vectors++;
        if (o_busy !== 1'b0 || o_fail !== 1'b1) begin
            errors++;
            $display("FAIL start while failed: busy=%b fail=%b want 0 1", o_busy, o_fail);
        end
        clear_fail = 1'b1; start = 1'b1;
        tick();
        clear_fail = 1'b0; start = 1'b0;
        m_fail = 1'b0;
        vectors++;
        if (o_busy !== 1'b0 || o_fail !== 1'b0) begin
            errors++;
            $display("FAIL clear with start: busy=%b fail=%b want 0 0", o_busy, o_fail);
        end
        start_and_warmup();
        collect(0, 8'h00, 64);
        handshake(1'b0);
    endtask

    task automatic test_zero();
        sel = 1'b1; lim = 9; m_rcnt = 0;
        start_and_warmup();
        collect(1, 8'h00, 64);
        clear_fail = 1'b1;
        tick();
        clear_fail = 1'b0;
        m_fail = 1'b0;
        vectors++;
        if (o_fail !== 1'b0) begin
            errors++;
            $display("FAIL zero clear: fail=%b want 0", o_fail);
        end
        sel = 1'b0; lim = 4; m_rcnt = 0;
    endtask

    task automatic test_reset_mid();
        start_and_warmup();
        collect(0, 8'h00, 20);
        #2;
        rst_n = 1'b1;
        #1;
        vectors++;
        if (o_word !== 64'd0 || o_valid !== 0 || o_busy !== 0 || o_fail !== 0 ||
            o_ro1 !== 0 || o_ro2 !== 0) begin
            errors++;
            $display("FAIL mid reset: word=%h valid=%b busy=%b fail=%b ro=%b%b want all 0",
                     o_word, o_valid, o_busy, o_fail, o_ro1, o_ro2);
        end
        tick();
        rst_n = 1'b0;
        m_fail = 0; m_rcnt = 0;
        start_and_warmup();
        collect(0, 8'h00, 64);
        handshake(1'b0);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_continuous();
        test_repetition();
        test_zero();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
